// File: rtl/chan_mux_pkg.sv
// Shared types and defaults for the registered channel multiplexer.
// The optional statistics counters are enabled with CHAN_MUX_STATS_EN.
package chan_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int CNT_W        = 16;

endpackage

// File: rtl/chan_mux_reg_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found starting
// at ptr and wrapping; the pointer register itself is owned by the caller.
module rr_arbiter
  import chan_mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic                grant_valid
);

  // ptr is always kept below CHANNELS by the owner, so the modulo wrap is exact
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!grant_valid && req[(int'(ptr) + i) % CHANNELS]) begin
        grant[(int'(ptr) + i) % CHANNELS] = 1'b1;
        grant_valid                       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_reg.sv
// Registered N-channel multiplexer with chip select, direct and round-robin
// scan modes; CHAN_MUX_STATS_EN adds accept and drop counters.
module chan_mux_reg
  import chan_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      cs,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
`ifdef CHAN_MUX_STATS_EN
  ,
  output logic [CNT_W-1:0]          accept_cnt,
  output logic [CNT_W-1:0]          drop_cyc
`endif
);

  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic                r_out_valid;
  logic                r_sel_err;
  logic [SEL_W-1:0]    r_ptr;

  mode_e               w_mode;
  logic                w_slot_free;
  logic                w_sel_bad;
  logic [CHANNELS-1:0] w_dir_grant;
  logic [CHANNELS-1:0] w_arb_grant;
  logic                w_arb_valid;
  logic [CHANNELS-1:0] w_grant;
  logic                w_grant_valid;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [WIDTH-1:0]    w_mux_data;
  logic [SEL_W-1:0]    w_ptr_next;
  logic                w_accept;

  assign w_mode      = mode_e'(mode);
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_sel_bad   = (int'(sel) >= CHANNELS);

  // An out-of-range sel matches no channel, so it simply yields no grant
  always_comb begin
    w_dir_grant = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_dir_grant[k] = (sel == SEL_W'(k)) && in_valid[k];
    end
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant       (w_arb_grant),
    .grant_valid (w_arb_valid)
  );

  always_comb begin
    w_grant = '0;
    if (cs) begin
      w_grant = (w_mode == MODE_SCAN) ? w_arb_grant : w_dir_grant;
    end
  end

  assign w_grant_valid = |w_grant;
  assign w_accept      = nreset && w_grant_valid && w_slot_free;
  assign in_ready      = w_accept ? w_grant : '0;

  always_comb begin
    w_grant_idx = '0;
    w_mux_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_grant[k]) begin
        w_grant_idx = SEL_W'(k);
        w_mux_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (int'(w_grant_idx) == CHANNELS - 1) ? '0
                                                           : w_grant_idx + SEL_W'(1);

  // Single-entry output register: load on accept, otherwise drain on out_ready
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_mux_data;
      r_out_chan  <= w_grant_idx;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // The scan pointer only moves on scan-mode accepts and survives mode switches
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr <= '0;
    end else if (w_accept && (w_mode == MODE_SCAN)) begin
      r_ptr <= w_ptr_next;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sel_err <= 1'b0;
    end else if (cs && (w_mode == MODE_DIRECT) && w_sel_bad) begin
      r_sel_err <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

`ifdef CHAN_MUX_STATS_EN
  logic [CNT_W-1:0] r_accept_cnt;
  logic [CNT_W-1:0] r_drop_cyc;

  // accept_cnt wraps freely; drop_cyc saturates so long stalls stay visible
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_accept_cnt <= '0;
      r_drop_cyc   <= '0;
    end else begin
      if (w_accept) begin
        r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      end
      if (cs && (|in_valid) && !w_accept && (r_drop_cyc != {CNT_W{1'b1}})) begin
        r_drop_cyc <= r_drop_cyc + CNT_W'(1);
      end
    end
  end

  assign accept_cnt = r_accept_cnt;
  assign drop_cyc   = r_drop_cyc;
`endif

endmodule

// File: doc/chan_mux_reg.md
Name: chan_mux_reg

Overview:
- Parametrised, registered N-channel multiplexer with chip select. Next generation of the lab's asynchronous select/decoder blocks.
- Each input channel has a valid/ready handshake. One channel is forwarded per cycle into a single output register drained by a valid/ready consumer.
- Two modes: direct select (sel picks the channel) and scan (round-robin over valid channels).
- Sits between several byte-stream producers and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 3, number of input channels (2..16)
- SEL_W, $clog2(CHANNELS), width of sel and out_chan (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- nreset  input  1  asynchronous active-low reset
- cs  input  1  chip select; 0 blocks all new accepts
- mode  input  1  0 = direct, 1 = scan
- sel  input  SEL_W  channel index in direct mode
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational, one-hot or zero)
- out_data  output  WIDTH  registered data
- out_chan  output  SEL_W  channel index of out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data this cycle
- sel_err  output  1  sticky: direct-mode sel >= CHANNELS while cs=1

Behaviour:
- Reset (async assert, sync-free deassert): out_valid=0, out_data=0, out_chan=0, sel_err=0, scan pointer=0. Any in-flight data is dropped. in_ready=0 while nreset=0.
- slot_free = !out_valid | out_ready. The output register is a single entry; no bypass; in_ready never depends on out_valid of the same channel.
- Grant g (combinational):
  - cs=0 -> none.
  - Direct mode: g=sel if sel<CHANNELS and in_valid[sel]. Otherwise none.
  - Scan mode: g = first k with in_valid[k], searching ptr, ptr+1, ... mod CHANNELS. None if no valids.
- in_ready[g] = slot_free. All other in_ready bits are 0. Accept = in_valid[g] & in_ready[g].
- On accept: next edge loads out_data=in_data[g], out_chan=g, out_valid=1. Latency is 1 cycle. Throughput is 1 word/cycle while out_ready=1.
- No accept and out_ready=1: out_valid clears. No accept and out_ready=0: register holds, and out_data/out_chan are stable while out_valid=1.
- Scan pointer: on accept in scan mode, ptr <= (g+1) mod CHANNELS, wrapping CHANNELS-1 -> 0. Unchanged in direct mode and on no-accept.
- cs falling while out_valid=1: the output still drains normally; only new accepts stop.
- Mode change takes effect in the same cycle (combinational grant). The pointer is retained across mode changes.
- sel_err: set on any cycle with cs=1, mode=0, sel>=CHANNELS. Cleared only by reset. Irrelevant when CHANNELS is a power of two (stays 0).

Optional Feature:
- Macro CHAN_MUX_STATS_EN.
- Defined: adds output accept_cnt [15:0], incremented on every accept, wrapping 0xFFFF -> 0, reset to 0; also adds output drop_cyc [15:0], counting cycles with cs=1, some in_valid, and no accept, saturating at 0xFFFF.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package chan_mux_pkg: mode_e enum (MODE_DIRECT=0, MODE_SCAN=1), default width/channel constants, counter width constant (16).
- Sub-module rr_arbiter: CHANNELS-wide request vector plus pointer in, one-hot grant plus valid out. Purely combinational; the pointer register lives in chan_mux_reg.

Test Plan:
- Reset/idle: nreset=0 then 1, all in_valid=0 -> out_valid=0, out_data=0x00, in_ready=0, sel_err=0.
- Direct pass: cs=1, mode=0, sel=1, in_valid=3'b010, data ch1=0xA5, out_ready=1 -> in_ready=3'b010; next cycle out_data=0xA5, out_chan=1, out_valid=1.
- Backpressure: out_valid=1 holding 0x11, out_ready=0, new word 0x22 on sel channel -> in_ready=0, out_data stays 0x11. Raise out_ready -> 0x22 appears the following cycle with no gap or loss.
- Scan fairness: mode=1, in_valid=3'b111 constant, data 0x10/0x20/0x30, out_ready=1 -> out_chan sequence 0,1,2,0,1 and out_data 0x10,0x20,0x30,0x10,...
- cs gating plus sel error: CHANNELS=3, cs=1, mode=0, sel=3 -> no accept, sel_err=1 and stays set. Drop cs with out_valid=1 -> word drains, and no further accepts occur.
- Stats (CHAN_MUX_STATS_EN): 5 accepts, then 3 stalled cycles -> accept_cnt=5, drop_cyc=3. Apply reset mid-stream -> both counters 0 and out_valid=0.
